stream_drain_reader: RTL and testbench

- Read-side wrapper that empties a DEPTH-entry buffer filled by the accelerator's write-side wrapper, which writes with an ascending mod-N address counter.
- On start, walks the buffer addresses downward from len-1 to 0 using a loadable mod-N down-counter.
- Issues one synchronous-read request per entry.
- Presents each returned word on a valid/ready output stream, then pulses done.

---
 rtl/stream_drain_reader.sv | 101 ++++++++++
 tb/tb_stream_drain_reader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_drain_reader.sv
// Read-side drain of a DEPTH-entry buffer: walks addresses len-1 down to 0, issues one
// synchronous read per entry and presents each word on a valid/ready stream, then pulses done.
module stream_drain_reader #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned AW    = 3,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StPresent, StDone} state_e;

  localparam logic [AW:0]   DepthLen = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LenOne   = (AW+1)'(1);
  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
  localparam logic [AW-1:0] AddrOne  = AW'(1);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      // Abort: drop the stream but keep the last word on out_data.
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len == '0) begin
              state_d = StDone;
            end else begin
              state_d = StIssue;
              addr_d  = (len > DepthLen) ? LastAddr : AW'(len - LenOne);
            end
          end
        end
        StIssue: state_d = StCapture;
        StCapture: begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          state_d     = StPresent;
        end
        StPresent: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            // Address 0 is the terminal count; the counter never wraps.
            if (addr_q == '0) begin
              state_d = StDone;
            end else begin
              addr_d  = addr_q - AddrOne;
              state_d = StIssue;
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_en     = (state_q == StIssue);
  assign rd_addr   = addr_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_stream_drain_reader.sv
// Bench for stream_drain_reader: directed drains plus random lengths, buffer contents and
// backpressure, checked against a queue-based model of the expected drain.
module tb_stream_drain_reader;
  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst, clr, start, out_ready;
  logic [AW:0]   len;
  logic          rd_en, out_valid, busy, done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, out_data;
  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  stream_drain_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer model.
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 ready always high (timing checked), 1 random ready, 2 four stall cycles first.
  task automatic run_drain(input int l, input int rmode, input bit poke);
    int            n, done_cnt, done_cyc, stall_left;
    int            exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            got_addr[$];
    logic [DW-1:0] got_data[$];
    int            rd_cyc[$];
    bit            stalled;
    logic [DW-1:0] held;
    n = (l > DEPTH) ? DEPTH : l;
    for (int i = n - 1; i >= 0; i--) begin
      exp_addr.push_back(i);
      exp_data.push_back(mem[i]);
    end
    done_cnt   = 0;
    done_cyc   = -1;
    stalled    = 1'b0;
    held       = '0;
    stall_left = (rmode == 2) ? 4 : 0;
    len   = (AW+1)'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
    len   = '0;
    for (int k = 0; k < 300; k++) begin
      check("busy_during_drain", busy, 1);
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
        check("hold_no_rd", rd_en, 0);
      end
      if (rd_en) begin
        got_addr.push_back(int'(rd_addr));
        rd_cyc.push_back(k);
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) got_data.push_back(out_data);
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (poke && k == 0) begin
        start = 1'b1;
        len   = (AW+1)'(1);
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      tick();
      start = 1'b0;
      len   = '0;
      if (done_cnt > 0) break;
    end
    out_ready = 1'b0;
    check("done_pulses", done_cnt, 1);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    check("valid_after_done", out_valid, 0);
    check("n_reads", got_addr.size(), n);
    check("n_words", got_data.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_addr.size()) check("rd_addr_seq", got_addr[i], exp_addr[i]);
      if (i < got_data.size()) check("out_data_seq", got_data[i], exp_data[i]);
    end
    if (rmode == 0) begin
      check("done_latency", done_cyc, 3 * n);
      for (int i = 0; i < n; i++)
        if (i < rd_cyc.size()) check("rd_en_spacing", rd_cyc[i], 3 * i);
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; start = 1'b0; len = '0; out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(16 + i);

    // Reset asserted between edges must take effect immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    rst = 1'b0;
    tick();

    run_drain(3, 0, 1'b0);  // basic
    run_drain(2, 2, 1'b0);  // backpressure on 0x11
    run_drain(0, 0, 1'b0);  // empty drain
    run_drain(7, 0, 1'b0);  // clamped to DEPTH

    // Abort from PRESENT of a len=4 drain.
    len = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; len = '0;
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    check("abort_in_present", out_valid, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_data_held", out_data, 8'h13);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_done", done, 0);
      check("abort_stays_idle", busy, 0);
    end

    run_drain(4, 0, 1'b1);  // start during ISSUE ignored

    // Async reset in the middle of ISSUE.
    len = 4'd3; start = 1'b1;
    tick();
    start = 1'b0; len = '0;
    check("pre_rst_rd_en", rd_en, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rd_en", rd_en, 0);
    check("async_busy", busy, 0);
    check("async_valid", out_valid, 0);
    check("async_rd_addr", rd_addr, 0);
    check("async_out_data", out_data, 0);
    check("async_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    run_drain(1, 0, 1'b0);

    // Random contents, lengths and backpressure.
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run_drain(int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
      repeat (int'($urandom_range(0, 2))) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
